// File: rtl/peak_meter_mc.sv
// Multi-channel peak-hold level meter with a decimated moving-average window per channel.
// Optional sticky clip flags are built only when PEAK_CLIP_EN is defined.
module peak_meter_mc #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DECIM      = 12,
  parameter int unsigned HOLD_CNT   = 8,
  parameter int unsigned DECAY_STEP = 1,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SAMPLE_VALID,
  input  logic [CH_W-1:0]          SAMPLE_CH,
  input  logic [DATA_W-1:0]        SAMPLE_DAT,
  input  logic                     CLIP_CLR,
  output logic [NUM_CH*DATA_W-1:0] MPEAK,
  output logic [NUM_CH*DATA_W-1:0] AVG,
  output logic [NUM_CH-1:0]        UPD,
  output logic [NUM_CH-1:0]        CLIP
);

  localparam int unsigned WIN    = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned DC_W   = 8;
  localparam int unsigned HOLD_W = 16;

  logic [DATA_W-1:0] win  [NUM_CH][WIN];
  logic [DC_W-1:0]   dcnt [NUM_CH];
  logic [HOLD_W-1:0] hold [NUM_CH];
  logic [DATA_W-1:0] peak [NUM_CH];
  logic [DATA_W-1:0] avg  [NUM_CH];
  logic [NUM_CH-1:0] upd;
  logic              pend;
  logic [CH_W-1:0]   pend_ch;

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] push;
  logic [DATA_W-1:0] cand     [NUM_CH];
  logic [DATA_W-1:0] peak_dec [NUM_CH];
  logic [DATA_W-1:0] peak_nxt [NUM_CH];
  logic [HOLD_W-1:0] hold_nxt [NUM_CH];
  logic [SUM_W-1:0]  pend_sum;
  logic              any_push;

  // Channel select, decimation push and peak/hold next-state per channel.
  always_comb begin
    any_push = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]      = SAMPLE_VALID && (SAMPLE_CH == CH_W'(c));
      push[c]     = sel[c] && (dcnt[c] == '0);
      cand[c]     = push[c] ? SAMPLE_DAT : win[c][0];
      peak_dec[c] = (32'(peak[c]) > DECAY_STEP) ? peak[c] - DATA_W'(DECAY_STEP) : '0;
      peak_nxt[c] = peak[c];
      hold_nxt[c] = hold[c];
      if (cand[c] > peak[c]) begin
        peak_nxt[c] = cand[c];
        hold_nxt[c] = '0;
      end else if (32'(hold[c]) == HOLD_CNT) begin
        peak_nxt[c] = peak_dec[c];
        hold_nxt[c] = '0;
      end else begin
        hold_nxt[c] = hold[c] + HOLD_W'(1);
      end
      any_push = any_push | push[c];
    end
  end

  // Window sum of the channel pushed on the previous edge.
  always_comb begin
    pend_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_ch == CH_W'(c)) begin
        for (int i = 0; i < WIN; i++) begin
          pend_sum = pend_sum + SUM_W'(win[c][i]);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend    <= 1'b0;
      pend_ch <= '0;
      upd     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        dcnt[c] <= '0;
        hold[c] <= '0;
        peak[c] <= '0;
        avg[c]  <= '0;
        for (int i = 0; i < WIN; i++) begin
          win[c][i] <= '0;
        end
      end
    end else begin
      pend    <= any_push;
      pend_ch <= SAMPLE_CH;
      for (int c = 0; c < NUM_CH; c++) begin
        upd[c] <= pend && (pend_ch == CH_W'(c));
        if (pend && (pend_ch == CH_W'(c))) begin
          avg[c] <= DATA_W'(pend_sum >> AVG_LOG2);
        end
        if (sel[c]) begin
          dcnt[c] <= (32'(dcnt[c]) == DECIM - 1) ? '0 : dcnt[c] + DC_W'(1);
          peak[c] <= peak_nxt[c];
          hold[c] <= hold_nxt[c];
        end
        if (push[c]) begin
          win[c][0] <= SAMPLE_DAT;
          for (int i = 1; i < WIN; i++) begin
            win[c][i] <= win[c][i-1];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign MPEAK[g*DATA_W +: DATA_W] = peak[g];
    assign AVG[g*DATA_W +: DATA_W]   = avg[g];
  end

  assign UPD = upd;

`ifdef PEAK_CLIP_EN
  logic [NUM_CH-1:0] clip;

  // A full-scale sample sets the flag; a same-edge clear loses to the set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clip <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel[c] && (SAMPLE_DAT == '1)) begin
          clip[c] <= 1'b1;
        end else if (CLIP_CLR) begin
          clip[c] <= 1'b0;
        end
      end
    end
  end

  assign CLIP = clip;
`else
  logic unused_clip_clr;
  assign unused_clip_clr = CLIP_CLR;
  assign CLIP = '0;
`endif

endmodule

// File: tb/tb_peak_meter_mc.sv
// Directed bench for peak_meter_mc: three parameterisations share one stimulus stream.
module tb_peak_meter_mc;

`ifdef PEAK_CLIP_EN
  localparam int CLIP_ON = 1;
`else
  localparam int CLIP_ON = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  ch = '0;
  logic [11:0] dat = '0;
  logic        clr = 1'b0;

  logic [47:0] mpeak_a, avg_a, mpeak_b, avg_b;
  logic [35:0] mpeak_c, avg_c;
  logic [3:0]  upd_a, clip_a, upd_b, clip_b;
  logic [2:0]  upd_c, clip_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  peak_meter_mc #(.DATA_W(12), .NUM_CH(4), .AVG_LOG2(2), .DECIM(1), .HOLD_CNT(8), .DECAY_STEP(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .SAMPLE_VALID(valid), .SAMPLE_CH(ch), .SAMPLE_DAT(dat),
    .CLIP_CLR(clr), .MPEAK(mpeak_a), .AVG(avg_a), .UPD(upd_a), .CLIP(clip_a));

  peak_meter_mc #(.DATA_W(12), .NUM_CH(4), .AVG_LOG2(2), .DECIM(3), .HOLD_CNT(8), .DECAY_STEP(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .SAMPLE_VALID(valid), .SAMPLE_CH(ch), .SAMPLE_DAT(dat),
    .CLIP_CLR(clr), .MPEAK(mpeak_b), .AVG(avg_b), .UPD(upd_b), .CLIP(clip_b));

  peak_meter_mc #(.DATA_W(12), .NUM_CH(3), .AVG_LOG2(2), .DECIM(1), .HOLD_CNT(8), .DECAY_STEP(600)) dut_c (
    .CLK(CLK), .RESET(RESET), .SAMPLE_VALID(valid), .SAMPLE_CH(ch), .SAMPLE_DAT(dat),
    .CLIP_CLR(clr), .MPEAK(mpeak_c), .AVG(avg_c), .UPD(upd_c), .CLIP(clip_c));

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic [11:0] dat;
    int          chk;
    int          peak_a;
    int          peak_c;
    int          avg_a;
    bit          chk_avg;
    logic [3:0]  upd_a;
  } vec_t;

  vec_t tbl[$];

  function automatic int fld(input logic [47:0] bus, input int c);
    return int'(bus[c*12 +: 12]);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] c, input logic [11:0] d, input logic cl);
    @(negedge CLK);
    RESET = r; valid = v; ch = c; dat = d; clr = cl;
    @(posedge CLK);
    #1;
  endtask

  function automatic void add(input logic v, input logic [1:0] c, input logic [11:0] d, input int k,
                              input int pa, input int pc, input int av, input bit ca, input logic [3:0] u);
    vec_t e;
    e.v = v; e.ch = c; e.dat = d; e.chk = k; e.peak_a = pa; e.peak_c = pc;
    e.avg_a = av; e.chk_avg = ca; e.upd_a = u;
    tbl.push_back(e);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Average ramp on ch1 (window of 4, every sample pushes).
    add(1, 2'd1, 12'd100, 1, 100, 100,   0, 1, 4'b0000);
    add(1, 2'd1, 12'd200, 1, 200, 200,  25, 1, 4'b0010);
    add(1, 2'd1, 12'd300, 1, 300, 300,  75, 1, 4'b0010);
    add(1, 2'd1, 12'd400, 1, 400, 400, 150, 1, 4'b0010);
    add(0, 2'd0, 12'd0,   1, 400, 400, 250, 1, 4'b0010);
    add(0, 2'd0, 12'd0,   1, 400, 400, 250, 1, 4'b0000);
    // Hold/decay on ch2: 500 then 18 zeros.
    add(1, 2'd2, 12'd500, 2, 500, 500, 0, 1, 4'b0000);
    for (int k = 1; k <= 18; k++) begin
      add(1, 2'd2, 12'd0, 2,
          (k < 9) ? 500 : ((k < 18) ? 499 : 498),
          (k < 9) ? 500 : 0,
          (k <= 4) ? 125 : 0, 1, 4'b0100);
    end
    add(0, 2'd0, 12'd0, 2, 498, 0, 0, 1, 4'b0100);

    // Reset and idle.
    step(1, 0, 2'd0, 12'd0, 0);
    step(1, 0, 2'd0, 12'd0, 0);
    step(0, 0, 2'd0, 12'd0, 0);
    chk("reset mpeak_a", longint'(mpeak_a), 0);
    chk("reset avg_a", longint'(avg_a), 0);
    chk("reset upd_a", longint'(upd_a), 0);
    chk("reset clip_a", longint'(clip_a), 0);
    chk("reset mpeak_c", longint'(mpeak_c), 0);

    foreach (tbl[i]) begin
      step(0, tbl[i].v, tbl[i].ch, tbl[i].dat, 0);
      chk($sformatf("vec%0d peak_a", i), fld(mpeak_a, tbl[i].chk), tbl[i].peak_a);
      chk($sformatf("vec%0d peak_c", i), fld(48'(mpeak_c), tbl[i].chk), tbl[i].peak_c);
      if (tbl[i].chk_avg) chk($sformatf("vec%0d avg_a", i), fld(avg_a, tbl[i].chk), tbl[i].avg_a);
      chk($sformatf("vec%0d upd_a", i), longint'(upd_a), longint'(tbl[i].upd_a));
      if (i == 5) begin
        chk("avg ch0 untouched", fld(avg_a, 0), 0);
        chk("avg ch3 untouched", fld(avg_a, 3), 0);
        chk("peak ch0 untouched", fld(mpeak_a, 0), 0);
      end
    end
    chk("no clip below full scale", longint'(clip_a), 0);

    // Reset dominates a simultaneous full-scale sample.
    step(0, 1, 2'd3, 12'd4095, 0);
    step(1, 1, 2'd3, 12'd4095, 0);
    chk("reset dom mpeak_a", longint'(mpeak_a), 0);
    chk("reset dom avg_a", longint'(avg_a), 0);
    chk("reset dom clip_a", longint'(clip_a), 0);
    chk("reset dom upd_a", longint'(upd_a), 0);

    // Decimation by 3 on ch0 of dut_b: only 10 and 40 enter the window.
    step(0, 1, 2'd0, 12'd10, 0);
    chk("dec s10 peak", fld(mpeak_b, 0), 10);
    chk("dec s10 upd", longint'(upd_b), 0);
    step(0, 1, 2'd0, 12'd20, 0);
    chk("dec s20 upd", longint'(upd_b), 1);
    chk("dec s20 avg", fld(avg_b, 0), 2);
    chk("dec s20 peak", fld(mpeak_b, 0), 10);
    step(0, 1, 2'd0, 12'd30, 0);
    chk("dec s30 upd", longint'(upd_b), 0);
    chk("dec s30 peak", fld(mpeak_b, 0), 10);
    step(0, 1, 2'd0, 12'd40, 0);
    chk("dec s40 upd", longint'(upd_b), 0);
    chk("dec s40 peak", fld(mpeak_b, 0), 40);
    step(0, 0, 2'd0, 12'd0, 0);
    chk("dec post upd", longint'(upd_b), 1);
    chk("dec post avg", fld(avg_b, 0), 12);
    step(0, 0, 2'd0, 12'd0, 0);
    chk("dec idle upd", longint'(upd_b), 0);
    chk("dec clip_b", longint'(clip_b), 0);

    // Channel guard on the 3-channel instance, clip set on the 4-channel one.
    step(1, 0, 2'd0, 12'd0, 0);
    step(0, 1, 2'd3, 12'd4095, 0);
    chk("guard mpeak_c", longint'(mpeak_c), 0);
    chk("guard avg_c", longint'(avg_c), 0);
    chk("guard clip_c", longint'(clip_c), 0);
    chk("ch3 peak_a", fld(mpeak_a, 3), 4095);
    chk("clip set", longint'(clip_a[3]), CLIP_ON);
    step(0, 0, 2'd0, 12'd0, 0);
    chk("guard upd_c", longint'(upd_c), 0);
    chk("ch3 upd_a", longint'(upd_a), 8);
    chk("clip persists", longint'(clip_a), CLIP_ON * 8);

    // Back-to-back channels.
    step(0, 1, 2'd0, 12'd7, 0);
    chk("interleave c0", fld(48'(mpeak_c), 0), 7);
    step(0, 1, 2'd1, 12'd9, 0);
    chk("interleave c1", fld(48'(mpeak_c), 1), 9);
    chk("interleave c0 hold", fld(48'(mpeak_c), 0), 7);

    // Clear racing a new clip event, then a bare clear.
    step(0, 1, 2'd3, 12'd4095, 1);
    chk("clip set beats clr", longint'(clip_a), CLIP_ON * 8);
    step(0, 0, 2'd0, 12'd0, 1);
    chk("clip cleared", longint'(clip_a), 0);
    step(0, 0, 2'd0, 12'd0, 0);
    chk("clip stays clear", longint'(clip_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peak_meter_mc.md
Name: peak_meter_mc

Overview:
- Multi-channel, parametrised peak-hold level meter for the sample-data path. Sits after the ADC sample capture and feeds display/LED bar logic.
- Accepts time-multiplexed, channel-tagged samples. Per channel it provides:
  - a decimated moving-average window;
  - a peak-hold value with programmable hold time and decay step;
  - a sticky clip indicator (optional).
- Everything runs in the CLK domain; no sample-strobe clocking.

Parameters:
- DATA_W, 12, sample and peak width in bits (unsigned).
- NUM_CH, 4, number of channels (1..16).
- AVG_LOG2, 2, log2 of moving-average depth (window = 2^AVG_LOG2 entries; 0..4).
- DECIM, 12, accepted samples per channel between window pushes (1..255).
- HOLD_CNT, 8, accepted samples a peak is held before each decay step (0..2^16-1).
- DECAY_STEP, 1, amount subtracted from the peak per decay event.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- SAMPLE_VALID  in  1  one-cycle qualifier for SAMPLE_CH/SAMPLE_DAT
- SAMPLE_CH  in  CH_W  channel tag, where CH_W = max(1, clog2(NUM_CH))
- SAMPLE_DAT  in  DATA_W  unsigned sample
- CLIP_CLR  in  1  clears all clip flags (PEAK_CLIP_EN only)
- MPEAK  out  NUM_CH*DATA_W  packed peak-hold values; channel c at [c*DATA_W +: DATA_W]
- AVG  out  NUM_CH*DATA_W  packed window averages, same packing
- UPD  out  NUM_CH  one-cycle pulse per channel when its AVG updates
- CLIP  out  NUM_CH  sticky clip flags

Behaviour:
- Reset: one clock, synchronous, active-high. While RESET=1 on a CLK edge:
  - all window entries, MPEAK, AVG, UPD, CLIP cleared to 0;
  - decimation counters and hold counters cleared to 0;
  - RESET dominates every simultaneous input.
  - Reset mid-operation discards all window history.
- Accept: a sample is accepted on a CLK edge when SAMPLE_VALID=1 and SAMPLE_CH < NUM_CH.
  - Out-of-range channel: ignored entirely; no state changes.
  - Only the addressed channel's state changes; all other channels hold.
- Decimation, per channel, counter dcnt in 0..DECIM-1, on each accepted sample:
  - push = (dcnt == 0);
  - dcnt <= (dcnt == DECIM-1) ? 0 : dcnt+1;
  - DECIM=1 → every sample pushes.
- Window: on push, the channel's shift register shifts by one; SAMPLE_DAT enters the newest slot and the oldest entry is dropped.
  - Sum width DATA_W+AVG_LOG2, no overflow.
  - AVG[c] <= sum >> AVG_LOG2 (truncating), registered.
  - AVG and UPD[c]=1 appear on the clock edge after the push edge (latency 1).
  - UPD is 0 in all other cycles.
  - Startup: zero entries count, so the average ramps up after reset.
- Peak candidate v = SAMPLE_DAT if push, else the channel's newest window entry.
- Peak, on each accepted sample:
  - If v > MPEAK[c]: MPEAK[c] <= v and hold counter <= 0.
  - Else if hold == HOLD_CNT: hold <= 0 and MPEAK[c] <= MPEAK[c] - DECAY_STEP, saturating at 0.
  - Else hold <= hold+1.
  - MPEAK is updated on the same edge as the acceptance (latency 0 registered).
  - HOLD_CNT=0 → decay on every non-increasing sample.
  - A new peak on the same sample a decay would fire: the new peak wins.
- Samples on back-to-back cycles, including the same channel, must all be processed; no stall, no backpressure.

Optional Feature:
- Macro: PEAK_CLIP_EN.
- Defined:
  - An accepted SAMPLE_DAT equal to all ones (2^DATA_W-1) sets CLIP[c].
  - CLIP_CLR=1 clears all CLIP bits.
  - If a clip event and CLIP_CLR occur on the same edge, the set wins for that channel.
- Not defined:
  - CLIP is tied to 0 and CLIP_CLR is ignored.
  - Ports remain for a stable interface; no clip logic is synthesised.

Test Plan:
- Reset/idle: RESET high 2 cycles, then no samples → MPEAK=AVG=0, UPD=0, CLIP=0.
- Average (DECIM=1, AVG_LOG2=2), ch1 samples 100,200,300,400:
  - AVG[1] = 25, 75, 150, 250, each one cycle after its sample with UPD[1] pulse;
  - other channels unchanged.
- Decimation (DECIM=3), ch0 samples 10,20,30,40: only 10 and 40 are pushed; UPD[0] pulses twice.
- Hold/decay (DECIM=1, HOLD_CNT=8, DECAY_STEP=1), ch2 samples 500 then 0 repeated:
  - MPEAK[2]=500 for the next 8 samples;
  - drops to 499 on the 9th;
  - drops to 498 on the 18th;
  - with DECAY_STEP=600 it saturates to 0.
- Channel guard/interleave (NUM_CH=3): SAMPLE_CH=3 with 4095 → no change; ch0=7 and ch1=9 on consecutive cycles → both MPEAK values captured.
- Clip (PEAK_CLIP_EN):
  - ch3 sample 4095 → CLIP[3]=1 next edge, persists;
  - CLIP_CLR together with a new 4095 on ch3 → stays 1;
  - CLIP_CLR alone → 0.
  - Without the macro, CLIP stays 0 throughout.
